// File: rtl/bcd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_ctrl_pkg
// Brief    : Shared state encoding and BCD constants for the serial BCD adder.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;
    localparam logic [4:0] DEC_TEN = 5'd10;

endpackage
`default_nettype wire

// File: rtl/bcd_serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_serial_add_ctrl_if
// Brief    : Operand/result handshake bundle for the serial BCD adder.
// Revision : 1.0 - initial release
// ============================================================================
interface bcd_serial_add_ctrl_if #(
    parameter int NBYTES = 4
);
    logic                  start;
    logic                  cin;
    logic [8*NBYTES-1:0]   a_in;
    logic [8*NBYTES-1:0]   b_in;
    logic                  busy;
    logic                  done;
    logic [8*NBYTES-1:0]   sum;
    logic                  cout;
    logic                  err;

    modport master (
        output start, cin, a_in, b_in,
        input  busy, done, sum, cout, err
    );

    modport slave (
        input  start, cin, a_in, b_in,
        output busy, done, sum, cout, err
    );
endinterface
`default_nettype wire

// File: rtl/bcd_byte_add.sv
`default_nettype none
// ============================================================================
// Module   : bcd_byte_add
// Brief    : Combinational two-digit BCD adder with decimal carry in/out.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_byte_add
    import bcd_ctrl_pkg::*;
(
    input  wire logic [7:0] a,
    input  wire logic [7:0] b,
    input  wire logic       ci,
    output logic      [7:0] s,
    output logic            co
);
    logic [4:0] w_t0;
    logic [4:0] w_t1;
    logic       w_c0;

    always_comb begin
        w_t0 = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, ci};
        w_c0 = (w_t0 >= DEC_TEN);
        s[3:0] = w_c0 ? (w_t0[3:0] + BCD_ADJ) : w_t0[3:0];
        w_t1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'd0, w_c0};
        co   = (w_t1 >= DEC_TEN);
        s[7:4] = co ? (w_t1[3:0] + BCD_ADJ) : w_t1[3:0];
    end
endmodule
`default_nettype wire

// File: rtl/bcd_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bcd_serial_add_ctrl
// Brief    : Byte-serial packed-BCD adder sequencer, LSB byte first.
//            Optional operand check enabled by macro BCD_OPERAND_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_serial_add_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    bcd_serial_add_ctrl_if.slave  bus
);
    localparam int              c_IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(NBYTES - 1);

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_idx;
    logic                 r_carry;
    logic [8*NBYTES-1:0]  r_a;
    logic [8*NBYTES-1:0]  r_b;
    logic [8*NBYTES-1:0]  r_sum;
    logic                 r_cout;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    logic [7:0]           w_a_byte;
    logic [7:0]           w_b_byte;
    logic [7:0]           w_s_byte;
    logic                 w_co;
    logic                 w_bad;

    assign w_a_byte = r_a[r_idx*8 +: 8];
    assign w_b_byte = r_b[r_idx*8 +: 8];

    bcd_byte_add u_byte_add (
        .a  (w_a_byte),
        .b  (w_b_byte),
        .ci (r_carry),
        .s  (w_s_byte),
        .co (w_co)
    );

`ifdef BCD_OPERAND_CHECK_EN
    always_comb begin
        w_bad = 1'b0;
        for (int n = 0; n < 2*NBYTES; n++) begin
            if ((bus.a_in[4*n +: 4] > BCD_MAX) || (bus.b_in[4*n +: 4] > BCD_MAX)) begin
                w_bad = 1'b1;
            end
        end
    end
`else
    assign w_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ADD: begin
                    // A start arriving here is deliberately ignored.
                    r_sum[r_idx*8 +: 8] <= w_s_byte;
                    r_carry             <= w_co;
                    if (r_idx == c_LAST) begin
                        r_idx   <= '0;
                        r_cout  <= w_co;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a     <= bus.a_in;
                        r_b     <= bus.b_in;
                        r_carry <= bus.cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_err   <= w_bad;
                        r_busy  <= 1'b1;
                        r_state <= ADD;
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.err  = r_err;
endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_serial_add_ctrl
// Brief    : Directed plus random checks of the serial BCD adder (2- and 1-byte).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_serial_add_ctrl;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    bcd_serial_add_ctrl_if #(.NBYTES(2)) bus2 ();
    bcd_serial_add_ctrl_if #(.NBYTES(1)) bus1 ();

    bcd_serial_add_ctrl #(.NBYTES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    bcd_serial_add_ctrl #(.NBYTES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef BCD_OPERAND_CHECK_EN
    localparam logic c_ERR_EXP = 1'b1;
`else
    localparam logic c_ERR_EXP = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Decimal reference: value(a)+value(b)+cin, reduced to 2*nb digits.
    function automatic logic [32:0] ref_add(input int nb, input logic [31:0] a,
                                             input logic [31:0] b, input logic c);
        longint va = 0;
        longint vb = 0;
        longint lim = 1;
        longint s;
        logic [31:0] r = '0;
        logic co;
        for (int d = 2*nb-1; d >= 0; d--) begin
            va  = va * 10 + longint'((a >> (4*d)) & 32'hF);
            vb  = vb * 10 + longint'((b >> (4*d)) & 32'hF);
            lim = lim * 10;
        end
        s  = va + vb + longint'(c);
        co = (s >= lim);
        s  = s % lim;
        for (int d = 0; d < 2*nb; d++) begin
            r[4*d +: 4] = 4'(s % 10);
            s = s / 10;
        end
        return {co, r};
    endfunction

    function automatic logic [31:0] rand_bcd(input int nb);
        logic [31:0] r = '0;
        for (int d = 0; d < 2*nb; d++) r[4*d +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    task automatic start2(input logic [15:0] a, input logic [15:0] b, input logic c);
        bus2.start = 1'b1; bus2.a_in = a; bus2.b_in = b; bus2.cin = c;
        tick();
        bus2.start = 1'b0; bus2.a_in = 16'($urandom); bus2.b_in = 16'($urandom);
        bus2.cin = 1'($urandom);
    endtask

    task automatic wait_done2(output int cyc);
        cyc = 1;
        while (bus2.done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run2(input logic [15:0] a, input logic [15:0] b, input logic c, input string tag);
        logic [32:0] e;
        int cyc;
        e = ref_add(2, {16'h0, a}, {16'h0, b}, c);
        start2(a, b, c);
        check({tag, "_busy"}, bus2.busy, 1);
        check({tag, "_err"},  bus2.err,  0);
        wait_done2(cyc);
        check({tag, "_lat"},  cyc, 3);
        check({tag, "_sum"},  bus2.sum, e[15:0]);
        check({tag, "_cout"}, bus2.cout, e[32]);
        check({tag, "_bsy0"}, bus2.busy, 0);
        tick();
        check({tag, "_pulse"}, bus2.done, 0);
    endtask

    task automatic run1(input logic [7:0] a, input logic [7:0] b, input logic c, input string tag);
        logic [32:0] e;
        int cyc;
        e = ref_add(1, {24'h0, a}, {24'h0, b}, c);
        bus1.start = 1'b1; bus1.a_in = a; bus1.b_in = b; bus1.cin = c;
        tick();
        bus1.start = 1'b0; bus1.a_in = 8'($urandom); bus1.b_in = 8'($urandom);
        check({tag, "_busy"}, bus1.busy, 1);
        cyc = 1;
        while (bus1.done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_lat"},  cyc, 2);
        check({tag, "_sum"},  bus1.sum, e[7:0]);
        check({tag, "_cout"}, bus1.cout, e[32]);
        tick();
        check({tag, "_pulse"}, bus1.done, 0);
    endtask

    initial begin
        int cyc;
        vectors = 0; miscompares = 0;
        rst = 1'b1;
        bus2.start = 1'b0; bus2.cin = 1'b0; bus2.a_in = '0; bus2.b_in = '0;
        bus1.start = 1'b0; bus1.cin = 1'b0; bus1.a_in = '0; bus1.b_in = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_busy", bus2.busy, 0);
        check("rst_done", bus2.done, 0);
        check("rst_sum",  bus2.sum,  0);
        check("rst_cout", bus2.cout, 0);
        check("rst_err",  bus2.err,  0);
        check("rst_sum1", bus1.sum,  0);

        run2(16'h1234, 16'h5678, 1'b0, "t1");
        run2(16'h9999, 16'h0001, 1'b0, "t2a");
        run2(16'h0099, 16'h0000, 1'b1, "t2b");

        // start re-pulsed mid-add, then back-to-back start from DONE
        start2(16'h1234, 16'h5678, 1'b0);
        bus2.start = 1'b1; bus2.a_in = 16'h1111; bus2.b_in = 16'h1111;
        tick();
        bus2.start = 1'b0;
        check("t3_busy", bus2.busy, 1);
        tick();
        check("t3_done", bus2.done, 1);
        check("t3_sum",  bus2.sum,  16'h6912);
        check("t3_cout", bus2.cout, 0);
        start2(16'h0099, 16'h0000, 1'b1);
        check("t3b_busy", bus2.busy, 1);
        check("t3b_done", bus2.done, 0);
        wait_done2(cyc);
        check("t3b_lat", cyc, 3);
        check("t3b_sum", bus2.sum, 16'h0100);
        tick();

        // reset during first ADD cycle
        start2(16'h4321, 16'h1111, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_busy", bus2.busy, 0);
        check("t4_sum",  bus2.sum,  0);
        check("t4_cout", bus2.cout, 0);
        for (int i = 0; i < 4; i++) begin
            check("t4_nodone", bus2.done, 0);
            tick();
        end
        run2(16'h0550, 16'h0450, 1'b0, "t4b");

        // non-BCD operand
        start2(16'h12A4, 16'h0001, 1'b0);
        check("t5_err1", bus2.err, c_ERR_EXP);
        wait_done2(cyc);
        check("t5_lat", cyc, 3);
        check("t5_err2", bus2.err, c_ERR_EXP);
        tick();
        check("t5_err3", bus2.err, c_ERR_EXP);
        run2(16'h0808, 16'h0202, 1'b0, "t5clr");

        for (int i = 0; i < 20; i++) begin
            run2(rand_bcd(2)[15:0], rand_bcd(2)[15:0], 1'($urandom), "rnd2");
        end

        run1(8'h95, 8'h07, 1'b0, "t6");
        for (int i = 0; i < 10; i++) begin
            run1(rand_bcd(1)[7:0], rand_bcd(1)[7:0], 1'($urandom), "rnd1");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
